// File: rtl/mips_pkg.sv
// Shared widths and limits for the writeback arbiter and its multiply/divide
// result buffer.
package mips_pkg;
  localparam int REG_ADDR_W   = 5;
  localparam int DATA_W       = 32;
  localparam int STARVE_LIMIT = 3;
  localparam int STARVE_W     = $clog2(STARVE_LIMIT + 1);

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0]     data_t;
endpackage

// File: rtl/wb_md_buffer.sv
// One-entry holding buffer for multiply/divide results with a valid/ready
// input handshake; the arbiter empties it through drain or drop.
module wb_md_buffer
  import mips_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  logic      md_valid,
  input  reg_addr_t md_reg,
  input  data_t     md_data,
  input  logic      drain,
  input  logic      drop,
  output logic      md_ready,
  output logic      full,
  output reg_addr_t buf_reg,
  output data_t     buf_data
);
  logic accept;

  // Accepting only while empty keeps drain and accept on separate edges.
  assign md_ready = ~full;
  assign accept   = md_valid & md_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full    <= 1'b0;
      buf_reg <= '0;
    end else if (accept) begin
      full    <= (md_reg != '0);
      buf_reg <= md_reg;
    end else if (drain || drop) begin
      full    <= 1'b0;
    end
  end

  // Payload needs no reset: it is only observed while full is set.
  always_ff @(posedge clk) begin
    if (accept) begin
      buf_data <= md_data;
    end
  end
endmodule

// File: rtl/writeback_arbiter.sv
// Register-file write port arbiter: pipeline writebacks have priority over
// buffered multiply/divide results, with a starvation stall to force a drain.
module writeback_arbiter
  import mips_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  logic      wb_valid,
  input  logic      wb_regwrite,
  input  logic      wb_memtoreg,
  input  reg_addr_t wb_reg,
  input  data_t     wb_alu_result,
  input  data_t     wb_mem_data,
  input  logic      md_valid,
  input  reg_addr_t md_reg,
  input  data_t     md_data,
  output logic      md_ready,
  output logic      wb_stall,
  output logic      RegWrite,
  output reg_addr_t WriteReg,
  output data_t     WriteData
);
  logic                buf_full;
  reg_addr_t           buf_reg;
  data_t               buf_data;
  logic [STARVE_W-1:0] starve_cnt;
  logic                pipe_wr_p0;
  logic                drain_p0;
  logic                drop_p0;
  logic                blocked_p0;
  data_t               pipe_data_p0;

  wb_md_buffer u_md_buffer (
    .clk      (clk),
    .rst_n    (rst_n),
    .md_valid (md_valid),
    .md_reg   (md_reg),
    .md_data  (md_data),
    .drain    (drain_p0),
    .drop     (drop_p0),
    .md_ready (md_ready),
    .full     (buf_full),
    .buf_reg  (buf_reg),
    .buf_data (buf_data)
  );

  // Stage p0: arbitration between the pipeline slot and the md buffer.
  assign wb_stall     = buf_full && (starve_cnt == STARVE_W'(STARVE_LIMIT));
  assign pipe_wr_p0   = wb_valid & wb_regwrite & (wb_reg != '0) & ~wb_stall;
  assign drain_p0     = buf_full & ~pipe_wr_p0;
  assign drop_p0      = buf_full & pipe_wr_p0 & (wb_reg == buf_reg);
  assign blocked_p0   = buf_full & pipe_wr_p0 & ~drop_p0;
  assign pipe_data_p0 = wb_memtoreg ? wb_mem_data : wb_alu_result;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (!blocked_p0) begin
      starve_cnt <= '0;
    end else if (starve_cnt != STARVE_W'(STARVE_LIMIT)) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

  // Stage p1: registered register-file write port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      RegWrite  <= 1'b0;
      WriteReg  <= '0;
      WriteData <= '0;
    end else if (pipe_wr_p0) begin
      RegWrite  <= 1'b1;
      WriteReg  <= wb_reg;
      WriteData <= pipe_data_p0;
    end else if (drain_p0) begin
      RegWrite  <= 1'b1;
      WriteReg  <= buf_reg;
      WriteData <= buf_data;
    end else begin
      RegWrite  <= 1'b0;
    end
  end
endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed testbench for writeback_arbiter: pipeline writes, md buffer
// handshake, starvation stall, same-register drop and mid-operation reset.
module tb_writeback_arbiter;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        wb_valid, wb_regwrite, wb_memtoreg;
  logic [4:0]  wb_reg;
  logic [31:0] wb_alu_result, wb_mem_data;
  logic        md_valid;
  logic [4:0]  md_reg;
  logic [31:0] md_data;
  logic        md_ready, wb_stall, RegWrite;
  logic [4:0]  WriteReg;
  logic [31:0] WriteData;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  writeback_arbiter dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .wb_valid      (wb_valid),
    .wb_regwrite   (wb_regwrite),
    .wb_memtoreg   (wb_memtoreg),
    .wb_reg        (wb_reg),
    .wb_alu_result (wb_alu_result),
    .wb_mem_data   (wb_mem_data),
    .md_valid      (md_valid),
    .md_reg        (md_reg),
    .md_data       (md_data),
    .md_ready      (md_ready),
    .wb_stall      (wb_stall),
    .RegWrite      (RegWrite),
    .WriteReg      (WriteReg),
    .WriteData     (WriteData)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pipe(input logic [4:0] r, input logic [31:0] alu);
    wb_valid = 1'b1; wb_regwrite = 1'b1; wb_memtoreg = 1'b0;
    wb_reg = r; wb_alu_result = alu;
  endtask

  task automatic pipe_idle();
    wb_valid = 1'b0; wb_regwrite = 1'b0; wb_memtoreg = 1'b0;
    wb_reg = 5'd0; wb_alu_result = 32'h0;
  endtask

  task automatic md(input logic v, input logic [4:0] r, input logic [31:0] d);
    md_valid = v; md_reg = r; md_data = d;
  endtask

  task automatic chk_wr(input string tag, input logic rw, input logic [4:0] r, input logic [31:0] d);
    check({tag, ".RegWrite"}, {31'h0, RegWrite}, {31'h0, rw});
    check({tag, ".WriteReg"}, {27'h0, WriteReg}, {27'h0, r});
    check({tag, ".WriteData"}, WriteData, d);
  endtask

  initial begin
    rst_n = 1'b0;
    pipe_idle();
    wb_mem_data = 32'hAAAA_AAAA;
    md(1'b0, 5'd0, 32'h0);
    tick(); tick();
    chk_wr("reset", 1'b0, 5'd0, 32'h0);
    check("reset.md_ready", {31'h0, md_ready}, 32'd1);
    check("reset.wb_stall", {31'h0, wb_stall}, 32'd0);
    rst_n = 1'b1;
    tick();
    chk_wr("idle", 1'b0, 5'd0, 32'h0);

    // Basic ALU write, one cycle only
    pipe(5'd8, 32'h0000_1234);
    tick();
    chk_wr("alu_wr", 1'b1, 5'd8, 32'h0000_1234);
    pipe_idle();
    tick();
    chk_wr("alu_wr_end", 1'b0, 5'd8, 32'h0000_1234);

    // Memory data select
    pipe(5'd3, 32'h0BAD_0BAD);
    wb_memtoreg = 1'b1; wb_mem_data = 32'hCAFE_F00D;
    tick();
    chk_wr("mem_wr", 1'b1, 5'd3, 32'hCAFE_F00D);
    pipe(5'd4, 32'h1);
    wb_regwrite = 1'b0;
    tick();
    chk_wr("no_regwrite", 1'b0, 5'd3, 32'hCAFE_F00D);

    // Writes to r0 are suppressed on both paths
    pipe(5'd0, 32'hFFFF_FFFF);
    tick();
    chk_wr("pipe_r0", 1'b0, 5'd3, 32'hCAFE_F00D);
    pipe_idle();
    md(1'b1, 5'd0, 32'h1234_5678);
    tick();
    md(1'b0, 5'd0, 32'h0);
    check("md_r0.md_ready", {31'h0, md_ready}, 32'd1);
    check("md_r0.RegWrite", {31'h0, RegWrite}, 32'd0);
    tick();
    chk_wr("md_r0_after", 1'b0, 5'd3, 32'hCAFE_F00D);

    // md transfer with idle pipeline; second transfer refused on drain edge
    md(1'b1, 5'd5, 32'hDEAD_BEEF);
    tick();
    check("md5.md_ready_N", {31'h0, md_ready}, 32'd0);
    check("md5.RegWrite_N", {31'h0, RegWrite}, 32'd0);
    md(1'b1, 5'd6, 32'h0000_0066);
    tick();
    chk_wr("md5_drain", 1'b1, 5'd5, 32'hDEAD_BEEF);
    check("md5.md_ready_N1", {31'h0, md_ready}, 32'd1);
    tick();
    check("md6.accept_RegWrite", {31'h0, RegWrite}, 32'd0);
    check("md6.md_ready", {31'h0, md_ready}, 32'd0);
    md(1'b0, 5'd0, 32'h0);
    tick();
    chk_wr("md6_drain", 1'b1, 5'd6, 32'h0000_0066);

    // Starvation: buffer reg 5 blocked by writes to 9,10,11
    md(1'b1, 5'd5, 32'h0000_0055);
    pipe(5'd4, 32'h0000_0044);
    tick();
    md(1'b0, 5'd0, 32'h0);
    chk_wr("starve_load", 1'b1, 5'd4, 32'h0000_0044);
    check("starve_load.md_ready", {31'h0, md_ready}, 32'd0);
    pipe(5'd9, 32'h0000_0009);
    tick();
    chk_wr("starve_w9", 1'b1, 5'd9, 32'h0000_0009);
    check("starve_w9.stall", {31'h0, wb_stall}, 32'd0);
    pipe(5'd10, 32'h0000_000A);
    tick();
    chk_wr("starve_w10", 1'b1, 5'd10, 32'h0000_000A);
    check("starve_w10.stall", {31'h0, wb_stall}, 32'd0);
    pipe(5'd11, 32'h0000_000B);
    tick();
    chk_wr("starve_w11", 1'b1, 5'd11, 32'h0000_000B);
    check("starve_w11.stall", {31'h0, wb_stall}, 32'd1);
    pipe(5'd12, 32'h0000_000C);
    tick();
    chk_wr("starve_drain", 1'b1, 5'd5, 32'h0000_0055);
    check("starve_drain.stall", {31'h0, wb_stall}, 32'd0);
    check("starve_drain.md_ready", {31'h0, md_ready}, 32'd1);
    tick();
    chk_wr("starve_resume", 1'b1, 5'd12, 32'h0000_000C);
    pipe_idle();
    tick();
    check("starve_idle.RegWrite", {31'h0, RegWrite}, 32'd0);

    // Same-register write drops the buffered entry
    md(1'b1, 5'd7, 32'h1111_1111);
    pipe(5'd2, 32'h0000_0022);
    tick();
    md(1'b0, 5'd0, 32'h0);
    chk_wr("drop_load", 1'b1, 5'd2, 32'h0000_0022);
    pipe(5'd7, 32'h2222_2222);
    tick();
    chk_wr("drop_w7", 1'b1, 5'd7, 32'h2222_2222);
    check("drop.md_ready", {31'h0, md_ready}, 32'd1);
    pipe_idle();
    tick();
    chk_wr("drop_after", 1'b0, 5'd7, 32'h2222_2222);

    // Reset while buffer full
    md(1'b1, 5'd6, 32'h6666_6666);
    pipe(5'd3, 32'h0000_0033);
    tick();
    md(1'b0, 5'd0, 32'h0);
    pipe_idle();
    check("rst_load.md_ready", {31'h0, md_ready}, 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk_wr("rst_async", 1'b0, 5'd0, 32'h0);
    check("rst_async.md_ready", {31'h0, md_ready}, 32'd1);
    check("rst_async.stall", {31'h0, wb_stall}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    chk_wr("rst_release", 1'b0, 5'd0, 32'h0);
    tick();
    chk_wr("rst_release2", 1'b0, 5'd0, 32'h0);
    check("rst_release.md_ready", {31'h0, md_ready}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/writeback_arbiter.md
WRITEBACK_ARBITER -- requirements
Module: writeback_arbiter

Interface
REQ-001 SHALL expose clk, input, 1, single clock; all state updates on posedge.
REQ-002 SHALL expose rst_n, input, 1, asynchronous active-low reset.
REQ-003 SHALL expose wb_valid, input, 1, pipeline writeback slot occupied this cycle.
REQ-004 SHALL expose wb_regwrite, input, 1, pipeline instruction writes a register.
REQ-005 SHALL expose wb_memtoreg, input, 1, select wb_mem_data (1) or wb_alu_result (0).
REQ-006 SHALL expose wb_reg, input, 5, pipeline destination register.
REQ-007 SHALL expose wb_alu_result and wb_mem_data, input, 32 each, pipeline result candidates.
REQ-008 SHALL expose md_valid, input, 1; md_reg, input, 5; md_data, input, 32; md_ready, output, 1: multiply/divide result channel with valid/ready handshake.
REQ-009 SHALL expose wb_stall, output, 1, upstream must hold its writeback inputs this cycle.
REQ-010 SHALL expose RegWrite, output, 1; WriteReg, output, 5; WriteData, output, 32: register-file write port, all registered.

Function
REQ-011 A pipeline write SHALL be a cycle with wb_valid=1, wb_regwrite=1, wb_reg!=0, wb_stall=0; all other pipeline inputs are ignored.
REQ-012 A pipeline write sampled at edge N SHALL drive RegWrite=1 with WriteReg=wb_reg and the selected data for exactly the cycle after edge N (1-cycle latency).
REQ-013 The md channel SHALL feed a 1-entry buffer; md_ready = buffer empty; handshake completes at a posedge with md_valid=1 and md_ready=1.
REQ-014 A handshake with md_reg=0 SHALL complete but SHALL be discarded (buffer stays empty).
REQ-015 A buffered entry SHALL drain at any edge with no pipeline write, driving RegWrite=1 with its reg/data in the next cycle; minimum md-to-RegWrite latency is 2 cycles.
REQ-016 Draining and accepting SHALL NOT happen on the same edge (md_ready low while full); a new transfer may complete at the edge after the drain edge.
REQ-017 Pipeline writes SHALL have priority; a starvation counter SHALL count edges at which a full buffer is blocked by a pipeline write, saturating at 3, cleared when the buffer empties.
REQ-018 While buffer full and counter=3, wb_stall SHALL be 1 (combinational from state); pipeline inputs are ignored that cycle and the buffer drains at the next edge.
REQ-019 If a pipeline write targets the same register as the full buffer, the buffer entry SHALL be dropped at that edge (younger result wins) and the counter cleared.
REQ-020 Any edge with no pipeline write and empty buffer SHALL drive RegWrite=0; WriteReg/WriteData hold their previous values.
REQ-021 RegWrite SHALL never be 1 with WriteReg=0.

Reset
REQ-022 rst_n low SHALL immediately force RegWrite=0, WriteReg=0, WriteData=0, buffer empty, counter 0, wb_stall=0, md_ready=1.
REQ-023 Reset asserted mid-operation SHALL discard any buffered entry without issuing it; the first edge after release behaves as from idle.

Structure
REQ-024 Shared package mips_pkg SHALL hold REG_ADDR_W=5, DATA_W=32, STARVE_LIMIT=3.
REQ-025 The md buffer plus handshake SHALL be a sub-module wb_md_buffer; arbitration, counter and output registers stay at top level.

Verification
REQ-026 Pipeline write reg 8, alu 0x0000_1234, memtoreg=0 at edge N -> RegWrite=1, WriteReg=8, WriteData=0x0000_1234 in cycle N+1 only.
REQ-027 Pipeline write reg 0 data 0xFFFF_FFFF -> RegWrite stays 0; md transfer reg 0 -> md_ready stays 1, no write.
REQ-028 md transfer reg 5 data 0xDEAD_BEEF with idle pipeline at edge N -> md_ready=0 after N; RegWrite=1, WriteReg=5 in cycle N+2; md_ready=1 again after N+1.
REQ-029 Buffer holds reg 5, pipeline writes regs 9,10,11 back-to-back -> wb_stall=1 in the cycle after the third, reg 5 written next, pipeline writes resume.
REQ-030 Buffer holds reg 7 0x1111_1111, pipeline writes reg 7 0x2222_2222 -> only 0x2222_2222 written; md_ready=1 next cycle.
REQ-031 rst_n pulsed low while buffer full -> all outputs zero immediately, md_ready=1, buffered value never appears on WriteData.
